// File: rtl/elevador_pkg.sv
// Shared definitions for the elevator controller slice.
//   estado_t     : controller state encoding (PARADO, MOVENDO, PORTA)
//   SUBIDA/DESCIDA: direction register values
//   larguraMin1  : clog2 with a floor of 1, used for index and counter widths
package elevador_pkg;

    typedef enum logic [1:0] {
        PARADO  = 2'd0,
        MOVENDO = 2'd1,
        PORTA   = 2'd2
    } estado_t;

    localparam logic SUBIDA  = 1'b1;
    localparam logic DESCIDA = 1'b0;

    function automatic int unsigned larguraMin1(input int unsigned n);
        int unsigned r;
        r = $clog2(n);
        if (r < 1) r = 1;
        return r;
    endfunction

endpackage

// File: rtl/gerenciador_requisicoes.sv
// Pending-call manager: latches call buttons into a registered set and
// reports whether any pending call lies above or below the current floor.
//   clock_in     : clock, rising edge
//   reset        : synchronous, active-high; empties the pending set
//   requisicao   : call buttons, one bit per floor (pulse is enough)
//   clear_onehot : floors to drop from the set on this edge
//   andar        : current floor index
//   pend         : registered pending set
//   acima/abaixo : some pending call is above / below andar
module gerenciador_requisicoes
    import elevador_pkg::*;
#(
    parameter int unsigned N_ANDARES = 4,
    parameter int unsigned W         = 2
) (
    input  logic                 clock_in,
    input  logic                 reset,
    input  logic [N_ANDARES-1:0] requisicao,
    input  logic [N_ANDARES-1:0] clear_onehot,
    input  logic [W-1:0]         andar,
    output logic [N_ANDARES-1:0] pend,
    output logic                 acima,
    output logic                 abaixo
);

    logic [31:0] andarExt;

    assign andarExt = 32'(andar);

    always_ff @(posedge clock_in) begin
        if (reset) begin
            pend <= '0;
        end else begin
            pend <= (pend | requisicao) & ~clear_onehot;
        end
    end

    always_comb begin
        acima  = 1'b0;
        abaixo = 1'b0;
        for (int unsigned i = 0; i < N_ANDARES; i++) begin
            if (pend[i] && (i > andarExt)) acima  = 1'b1;
            if (pend[i] && (i < andarExt)) abaixo = 1'b1;
        end
    end

endmodule

// File: rtl/controle_elevador_n_andares.sv
// Elevator controller for N floors with SCAN service order, per-floor travel
// time and a timed door-open phase.
//   clock_in     : clock, rising edge
//   reset        : synchronous, active-high; returns the car to floor 0 at once
//   requisicao   : call buttons, one bit per floor
//   andar        : current floor (registered)
//   S            : 1 while moving up
//   P            : 1 while the car is not moving (PARADO or PORTA)
//   porta_aberta : 1 while the door is open
//   pendentes    : registered pending-call set
module controle_elevador_n_andares
    import elevador_pkg::*;
#(
    parameter int unsigned N_ANDARES    = 4,
    parameter int unsigned CICLOS_ANDAR = 4,
    parameter int unsigned CICLOS_PORTA = 3,
    localparam int unsigned W           = larguraMin1(N_ANDARES)
) (
    input  logic                 clock_in,
    input  logic                 reset,
    input  logic [N_ANDARES-1:0] requisicao,
    output logic [W-1:0]         andar,
    output logic                 S,
    output logic                 P,
    output logic                 porta_aberta,
    output logic [N_ANDARES-1:0] pendentes
);

    localparam int unsigned WA = larguraMin1(CICLOS_ANDAR);
    localparam int unsigned WP = larguraMin1(CICLOS_PORTA);

    localparam logic [WA-1:0]        FIM_ANDAR = WA'(CICLOS_ANDAR - 1);
    localparam logic [WP-1:0]        FIM_PORTA = WP'(CICLOS_PORTA - 1);
    localparam logic [W-1:0]         ULTIMO    = W'(N_ANDARES - 1);
    localparam logic [N_ANDARES-1:0] BIT0      = {{(N_ANDARES-1){1'b0}}, 1'b1};

    estado_t              estado, estadoProx;
    logic                 dirUp, dirUpProx;
    logic [W-1:0]         andarProx;
    logic [WA-1:0]        contAndar, contAndarProx;
    logic [WP-1:0]        contPorta, contPortaProx;
    logic [N_ANDARES-1:0] pend;
    logic [N_ANDARES-1:0] clearOnehot;
    logic                 acima, abaixo;

    gerenciador_requisicoes #(
        .N_ANDARES (N_ANDARES),
        .W         (W)
    ) uRequisicoes (
        .clock_in     (clock_in),
        .reset        (reset),
        .requisicao   (requisicao),
        .clear_onehot (clearOnehot),
        .andar        (andar),
        .pend         (pend),
        .acima        (acima),
        .abaixo       (abaixo)
    );

    always_ff @(posedge clock_in) begin
        if (reset) begin
            estado    <= PARADO;
            dirUp     <= SUBIDA;
            andar     <= '0;
            contAndar <= '0;
            contPorta <= '0;
        end else begin
            estado    <= estadoProx;
            dirUp     <= dirUpProx;
            andar     <= andarProx;
            contAndar <= contAndarProx;
            contPorta <= contPortaProx;
        end
    end

    always_comb begin
        estadoProx    = estado;
        dirUpProx     = dirUp;
        andarProx     = andar;
        contAndarProx = contAndar;
        contPortaProx = contPorta;

        case (estado)
            PARADO: begin
                if (pend[andar]) begin
                    estadoProx    = PORTA;
                    contPortaProx = '0;
                end else if (dirUp ? acima : abaixo) begin
                    estadoProx    = MOVENDO;
                    contAndarProx = '0;
                end else if (dirUp ? abaixo : acima) begin
                    dirUpProx     = ~dirUp;
                    estadoProx    = MOVENDO;
                    contAndarProx = '0;
                end
            end

            MOVENDO: begin
                if (contAndar == FIM_ANDAR) begin
                    contAndarProx = '0;
                    if (dirUp && (andar != ULTIMO)) begin
                        andarProx = andar + 1'b1;
                    end else if (!dirUp && (andar != '0)) begin
                        andarProx = andar - 1'b1;
                    end
                    // acima/abaixo are relative to the floor being left; once
                    // pend[andarProx] is known to be 0 they equal "a call beyond
                    // the arrival floor" in the travel direction.
                    if (pend[andarProx]) begin
                        estadoProx    = PORTA;
                        contPortaProx = '0;
                    end else if (!(dirUp ? acima : abaixo)) begin
                        estadoProx = PARADO;
                    end
                end else begin
                    contAndarProx = contAndar + 1'b1;
                end
            end

            PORTA: begin
                if (contPorta == FIM_PORTA) begin
                    estadoProx    = PARADO;
                    contPortaProx = '0;
                end else begin
                    contPortaProx = contPorta + 1'b1;
                end
            end

            default: begin
                estadoProx = PARADO;
            end
        endcase
    end

    // Current-floor call is dropped on the edge entering the door phase and on
    // every edge taken while the door is open, so repeat presses are absorbed.
    always_comb begin
        clearOnehot = '0;
        if ((estado == PORTA) || (estadoProx == PORTA)) begin
            clearOnehot = BIT0 << andarProx;
        end
    end

    assign S            = (estado == MOVENDO) && (dirUp == SUBIDA);
    assign P            = (estado != MOVENDO);
    assign porta_aberta = (estado == PORTA);
    assign pendentes    = pend;

endmodule

// File: tb/tb_controle_elevador_n_andares.sv
module tb_controle_elevador_n_andares;

    localparam int CA = 4;
    localparam int CP = 3;

    logic       clock_in = 1'b0;
    logic       reset;
    logic [3:0] requisicao;
    logic [1:0] andar;
    logic       S, P, porta_aberta;
    logic [3:0] pendentes;

    int total = 0;
    int bad   = 0;

    controle_elevador_n_andares #(
        .N_ANDARES    (4),
        .CICLOS_ANDAR (CA),
        .CICLOS_PORTA (CP)
    ) dut (
        .clock_in     (clock_in),
        .reset        (reset),
        .requisicao   (requisicao),
        .andar        (andar),
        .S            (S),
        .P            (P),
        .porta_aberta (porta_aberta),
        .pendentes    (pendentes)
    );

    always #5 clock_in = ~clock_in;

    task automatic confere(input string tag, input logic [31:0] obs, input logic [31:0] esp);
        total++;
        if (obs !== esp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, esp, $time);
        end
    endtask

    // ---------------- reference model + scoreboard ----------------
    typedef struct {
        logic [1:0] andar;
        logic [3:0] pend;
        logic       s;
        logic       p;
        logic       porta;
    } esperado_t;

    esperado_t fila[$];

    int     mEstado = 0;   // 0 idle, 1 moving, 2 door open
    int     mAndar  = 0;
    bit     mSobe   = 1'b1;
    int     mCont   = 0;
    bit [3:0] mPend = '0;

    function automatic bit temAFrente(input bit sobe);
        for (int f = 0; f < 4; f++) begin
            if (mPend[f] && (sobe ? (f > mAndar) : (f < mAndar))) return 1'b1;
        end
        return 1'b0;
    endfunction

    always @(posedge clock_in) begin : modelo
        bit [3:0]  novo;
        int        anterior;
        esperado_t e;
        if (reset) begin
            mEstado = 0; mAndar = 0; mSobe = 1'b1; mCont = 0; mPend = '0;
        end else begin
            novo     = mPend | requisicao;
            anterior = mEstado;
            case (mEstado)
                0: begin
                    if (mPend[mAndar]) begin
                        mEstado = 2; mCont = 0;
                    end else if (temAFrente(mSobe)) begin
                        mEstado = 1; mCont = 0;
                    end else if (temAFrente(!mSobe)) begin
                        mSobe = !mSobe; mEstado = 1; mCont = 0;
                    end
                end
                1: begin
                    if (mCont == CA - 1) begin
                        mCont  = 0;
                        mAndar = mAndar + (mSobe ? 1 : -1);
                        if (mPend[mAndar])          mEstado = 2;
                        else if (!temAFrente(mSobe)) mEstado = 0;
                    end else begin
                        mCont++;
                    end
                end
                default: begin
                    if (mCont == CP - 1) begin
                        mEstado = 0; mCont = 0;
                    end else begin
                        mCont++;
                    end
                end
            endcase
            if (anterior == 2 || mEstado == 2) novo[mAndar] = 1'b0;
            mPend = novo;
        end
        e.andar = 2'(mAndar);
        e.pend  = mPend;
        e.s     = (mEstado == 1) && mSobe;
        e.p     = (mEstado != 1);
        e.porta = (mEstado == 2);
        fila.push_back(e);
    end

    always @(negedge clock_in) begin : placar
        esperado_t e;
        if (fila.size() > 0) begin
            e = fila.pop_front();
            confere("sb_andar", andar, e.andar);
            confere("sb_pend",  pendentes, e.pend);
            confere("sb_S",     S, e.s);
            confere("sb_P",     P, e.p);
            confere("sb_porta", porta_aberta, e.porta);
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic pulso(input logic [3:0] v);
        requisicao = v;
        @(negedge clock_in);
        requisicao = '0;
    endtask

    task automatic esperaAndar(input logic [1:0] alvo, input int limite);
        for (int i = 0; i < limite && andar != alvo; i++) @(negedge clock_in);
        confere("wait_andar", andar, alvo);
    endtask

    task automatic pulsoReset();
        reset = 1'b1;
        @(negedge clock_in);
        reset = 1'b0;
    endtask

    initial begin
        reset      = 1'b1;
        requisicao = '0;

        // 1: reset state
        repeat (2) @(negedge clock_in);
        confere("rst_andar", andar, 0);
        confere("rst_pend",  pendentes, 4'b0000);
        confere("rst_S",     S, 0);
        confere("rst_P",     P, 1);
        confere("rst_porta", porta_aberta, 0);
        reset = 1'b0;

        // 2: single call to floor 2 from idle at 0
        pulso(4'b0100);
        confere("t2_pend", pendentes, 4'b0100);
        confere("t2_P_idle", P, 1);
        @(negedge clock_in);
        confere("t2_P", P, 0);
        confere("t2_S", S, 1);
        repeat (3) @(negedge clock_in);
        confere("t2_still0", andar, 0);
        @(negedge clock_in);
        confere("t2_andar1", andar, 1);
        repeat (4) @(negedge clock_in);
        confere("t2_andar2", andar, 2);
        confere("t2_porta", porta_aberta, 1);
        confere("t2_clear", pendentes[2], 0);
        repeat (2) @(negedge clock_in);
        confere("t2_porta3", porta_aberta, 1);
        @(negedge clock_in);
        confere("t2_closed", porta_aberta, 0);
        confere("t2_idle", P, 1);

        // 3: intermediate stop, late call to same floor absorbed
        pulsoReset();
        pulso(4'b1000);
        @(negedge clock_in);
        pulso(4'b0010);
        repeat (3) @(negedge clock_in);
        confere("t3_stop1", andar, 1);
        confere("t3_porta1", porta_aberta, 1);
        pulso(4'b0010);
        confere("t3_absorb", pendentes, 4'b1000);
        esperaAndar(2'd3, 40);
        confere("t3_porta3", porta_aberta, 1);
        repeat (4) @(negedge clock_in);
        confere("t3_empty", pendentes, 4'b0000);
        confere("t3_idle", P, 1);

        // 4: serve 3 then reverse down to 0
        pulsoReset();
        pulso(4'b0100);
        esperaAndar(2'd2, 30);
        pulso(4'b1001);
        esperaAndar(2'd3, 30);
        confere("t4_porta3", porta_aberta, 1);
        repeat (4) @(negedge clock_in);
        confere("t4_S_down", S, 0);
        confere("t4_P_move", P, 0);
        esperaAndar(2'd2, 10);
        esperaAndar(2'd1, 10);
        confere("t4_S_down2", S, 0);
        esperaAndar(2'd0, 10);
        confere("t4_porta0", porta_aberta, 1);

        // 5: call for current floor while idle, repeat during open door
        pulso(4'b0010);
        esperaAndar(2'd1, 30);
        repeat (6) @(negedge clock_in);
        confere("t5_idle", P, 1);
        pulso(4'b0010);
        confere("t5_notyet", porta_aberta, 0);
        @(negedge clock_in);
        confere("t5_open", porta_aberta, 1);
        pulso(4'b0010);
        confere("t5_open2", porta_aberta, 1);
        @(negedge clock_in);
        confere("t5_open3", porta_aberta, 1);
        @(negedge clock_in);
        confere("t5_closed", porta_aberta, 0);
        confere("t5_nomove", andar, 1);
        confere("t5_pend", pendentes, 4'b0000);

        // 6: reset while moving past floor 2
        pulso(4'b1000);
        esperaAndar(2'd2, 20);
        confere("t6_moving", P, 0);
        pulsoReset();
        confere("t6_andar", andar, 0);
        confere("t6_pend",  pendentes, 4'b0000);
        confere("t6_P",     P, 1);
        confere("t6_S",     S, 0);
        repeat (20) @(negedge clock_in);
        confere("t6_stay", andar, 0);
        confere("t6_stayP", P, 1);

        // random traffic, checked by the scoreboard
        repeat (400) begin
            requisicao = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(1, 15)) : 4'b0000;
            reset      = ($urandom_range(0, 149) == 0);
            @(negedge clock_in);
        end
        requisicao = '0;
        reset      = 1'b0;
        repeat (2) @(negedge clock_in);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
